// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage of the in-order pipeline.
//
// Holds one instruction from decode and computes its result with a
// combinational alu. Divide and modulo instructions go to an iterative
// restoring divider, and the stage stalls until that divider finishes.
// Loads and stores issue a single data SRAM request in the cycle the
// instruction is handed to the memory stage. Stores use byte enables and
// replicated write data.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   flush             kill the held instruction and any divide in progress
//   ds2es_valid/bus   instruction offered by decode
//                     {alu_op, div_op, mem_size, load, mem_we, rf_we,
//                      rf_waddr, src1, src2, rkd, pc}
//   es_allowin        stage can accept an instruction this cycle
//   es2ms_valid/bus   instruction handed to memory
//                     {load, mem_size, rf_we, rf_waddr, result, pc}
//   ms_allowin        memory stage can accept
//   es_rf_zip         {load&valid, rf_we&valid, rf_waddr, result}, for hazard
//                     detection and forwarding
//   data_sram_*       memory request: enable, byte write enables, address,
//                     write data
//
// alu_op is one-hot. The bits are:
//   0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//   8 sll, 9 srl, 10 sra, 11 lui
// div_op is one-hot {div, mod, divu, modu}. div and mod are signed.
// mem_size encodes 0=B, 1=H, 2=W, 3=D.

module ex_stage_mc #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 12,
    parameter int DIV_EN   = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          ds2es_valid,
    input  logic [ALU_OP_W+46+3*XLEN-1:0] ds2es_bus,
    output logic                          es_allowin,
    output logic                          es2ms_valid,
    output logic [41+XLEN-1:0]            es2ms_bus,
    input  logic                          ms_allowin,
    output logic [7+XLEN-1:0]             es_rf_zip,
    output logic                          data_sram_en,
    output logic [XLEN/8-1:0]             data_sram_we,
    output logic [XLEN-1:0]               data_sram_addr,
    output logic [XLEN-1:0]               data_sram_wdata
);

    localparam int BUS_W = ALU_OP_W + 46 + 3 * XLEN;
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } divState_e;

    logic             esValid_q, esValid_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic             capture;
    logic             readyGo;

    logic [ALU_OP_W-1:0] aluOp;
    logic [3:0]          divOp;
    logic [1:0]          memSize;
    logic                isLoad, memWe, rfWe;
    logic [4:0]          rfWaddr;
    logic [XLEN-1:0]     src1, src2, rkd;
    logic [31:0]         pc;

    logic [XLEN-1:0] aluResult, divResult, esResult;

    divState_e        divState_q, divState_d;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             quoNeg_q, remNeg_q, dvz_q;
    logic             isDiv, isSigned, wantRem, divStart, divDone;
    logic [XLEN-1:0]  absA, absB, remNext, quoNext, quoFix, remFix;
    logic [XLEN:0]    remShift, trial;

    logic [OFF_W-1:0] byteOff;
    logic [NB-1:0]    weRaw, wordMask;

    assign {aluOp, divOp, memSize, isLoad, memWe, rfWe, rfWaddr,
            src1, src2, rkd, pc} = bus_q;

    // The handshake is the same as in the other stages. A flush drops the
    // held instruction and refuses the one decode is offering.
    assign es_allowin  = ~esValid_q | (readyGo & ms_allowin);
    assign es2ms_valid = esValid_q & readyGo & ~flush;
    assign capture     = ds2es_valid & es_allowin & ~flush;

    always_comb begin
        esValid_d = esValid_q;
        bus_d     = bus_q;
        if (flush) begin
            esValid_d = 1'b0;
        end else if (es_allowin) begin
            esValid_d = ds2es_valid;
        end
        if (capture) begin
            bus_d = ds2es_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            esValid_q <= 1'b0;
            bus_q     <= '0;
        end else begin
            esValid_q <= esValid_d;
            bus_q     <= bus_d;
        end
    end

    // One-hot alu. The shifter uses only the low log2(XLEN) bits of src2.
    always_comb begin
        aluResult = '0;
        if (aluOp[0])  aluResult = src1 + src2;
        if (aluOp[1])  aluResult = src1 - src2;
        if (aluOp[2])  aluResult = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
        if (aluOp[3])  aluResult = {{(XLEN-1){1'b0}}, src1 < src2};
        if (aluOp[4])  aluResult = src1 & src2;
        if (aluOp[5])  aluResult = ~(src1 | src2);
        if (aluOp[6])  aluResult = src1 | src2;
        if (aluOp[7])  aluResult = src1 ^ src2;
        if (aluOp[8])  aluResult = src1 << src2[SHW-1:0];
        if (aluOp[9])  aluResult = src1 >> src2[SHW-1:0];
        if (aluOp[10]) aluResult = XLEN'($signed(src1) >>> src2[SHW-1:0]);
        if (aluOp[11]) aluResult = src2;
    end

    // Divider operand preparation. The divider works on magnitudes, and the
    // signs are put back once the divide is finished.
    assign isDiv    = (DIV_EN != 0) && (|divOp);
    assign isSigned = divOp[3] | divOp[2];
    assign wantRem  = divOp[2] | divOp[0];
    assign divStart = esValid_q & isDiv & ~flush;
    assign absA     = (isSigned && src1[XLEN-1]) ? -src1 : src1;
    assign absB     = (isSigned && src2[XLEN-1]) ? -src2 : src2;

    // Divider state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            divState_q <= DIV_IDLE;
        end else begin
            divState_q <= divState_d;
        end
    end

    // Divider next-state logic. A flush returns to IDLE from any state.
    always_comb begin
        divState_d = divState_q;
        if (flush) begin
            divState_d = DIV_IDLE;
        end else begin
            case (divState_q)
                DIV_IDLE: if (divStart)                  divState_d = DIV_RUN;
                DIV_RUN:  if (cnt_q == CNT_W'(1))        divState_d = DIV_DONE;
                DIV_DONE: if (ms_allowin)                divState_d = DIV_IDLE;
                default:                                 divState_d = DIV_IDLE;
            endcase
        end
    end

    // Divider output decode.
    always_comb begin
        divDone = (divState_q == DIV_DONE);
    end

    assign readyGo = ~isDiv | divDone;

    // Restoring step. Shift the next dividend bit into the partial remainder,
    // then keep the difference if subtracting the divisor does not borrow.
    // When the divisor is zero the remainder only accumulates the dividend
    // bits. That gives remainder = dividend, and the quotient is forced
    // separately.
    always_comb begin
        remShift = {rem_q, quo_q[XLEN-1]};
        trial    = remShift - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            remNext = trial[XLEN-1:0];
            quoNext = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            remNext = remShift[XLEN-1:0];
            quoNext = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Divider datapath. The partial result is simply left behind on a flush,
    // because the next start reloads every register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            quoNeg_q <= 1'b0;
            remNeg_q <= 1'b0;
            dvz_q    <= 1'b0;
        end else if (divState_q == DIV_IDLE) begin
            if (divStart) begin
                rem_q    <= '0;
                quo_q    <= absA;
                dvs_q    <= absB;
                cnt_q    <= CNT_W'(XLEN);
                quoNeg_q <= isSigned & (src1[XLEN-1] ^ src2[XLEN-1]);
                remNeg_q <= isSigned & src1[XLEN-1];
                dvz_q    <= (src2 == '0);
            end
        end else if (divState_q == DIV_RUN) begin
            rem_q <= remNext;
            quo_q <= quoNext;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign quoFix    = dvz_q ? '1 : (quoNeg_q ? -quo_q : quo_q);
    assign remFix    = remNeg_q ? -rem_q : rem_q;
    assign divResult = wantRem ? remFix : quoFix;
    assign esResult  = isDiv ? divResult : aluResult;

    // The byte offset of the load is the low bits of result, so it does not
    // need its own field in the bus to memory.
    assign es2ms_bus = {isLoad, memSize, rfWe, rfWaddr, esResult, pc};
    assign es_rf_zip = {isLoad & esValid_q, rfWe & esValid_q, rfWaddr, esResult};

    // The request is tied to the handoff cycle, so a load or store stalled
    // by memory is issued exactly once.
    assign data_sram_en   = esValid_q & (isLoad | memWe) & ms_allowin & ~flush;
    assign data_sram_addr = aluResult;
    assign byteOff        = aluResult[OFF_W-1:0];
    assign wordMask       = (XLEN == 32) ? '1 : (NB'(15) << {byteOff[OFF_W-1], 2'b00});

    always_comb begin
        weRaw = '0;
        case (memSize)
            2'd0:    weRaw = NB'(1) << byteOff;
            2'd1:    weRaw = NB'(3) << {byteOff[OFF_W-1:1], 1'b0};
            2'd2:    weRaw = wordMask;
            default: weRaw = (XLEN == 64) ? '1 : '0;
        endcase
    end

    assign data_sram_we = (data_sram_en & memWe) ? weRaw : '0;

    // The store data is replicated across the bus, so the byte enables alone
    // choose the lanes that get written.
    always_comb begin
        data_sram_wdata = rkd;
        case (memSize)
            2'd0:    data_sram_wdata = {NB{rkd[7:0]}};
            2'd1:    data_sram_wdata = {(NB/2){rkd[15:0]}};
            2'd2:    data_sram_wdata = {(XLEN/32){rkd[31:0]}};
            default: data_sram_wdata = rkd;
        endcase
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed, self-checking bench for ex_stage_mc with XLEN=32.
// A table of single-cycle alu/load/store vectors is applied in a loop.
// Hand-written sequences cover the divider stall, flush, reset in the middle
// of a divide, and a store held back by the memory stage.

module tb_ex_stage_mc;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 12;
    localparam int BUS_W    = ALU_OP_W + 46 + 3 * XLEN;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    localparam logic [3:0] D_DIV  = 4'b1000;
    localparam logic [3:0] D_MOD  = 4'b0100;
    localparam logic [3:0] D_DIVU = 4'b0010;
    localparam logic [3:0] D_MODU = 4'b0001;

    logic               clk;
    logic               resetn;
    logic               flush;
    logic               ds2es_valid;
    logic [BUS_W-1:0]   ds2es_bus;
    logic               es_allowin;
    logic               es2ms_valid;
    logic [41+XLEN-1:0] es2ms_bus;
    logic               ms_allowin;
    logic [7+XLEN-1:0]  es_rf_zip;
    logic               data_sram_en;
    logic [XLEN/8-1:0]  data_sram_we;
    logic [XLEN-1:0]    data_sram_addr;
    logic [XLEN-1:0]    data_sram_wdata;

    int total;
    int bad;

    typedef struct {
        logic [11:0] aluOp;
        logic [1:0]  size;
        logic        ld;
        logic        st;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] rkd;
        logic [31:0] expResult;
        logic        expEn;
        logic [3:0]  expWe;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs[18];

    ex_stage_mc #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W), .DIV_EN(1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .ds2es_valid     (ds2es_valid),
        .ds2es_bus       (ds2es_bus),
        .es_allowin      (es_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .ms_allowin      (ms_allowin),
        .es_rf_zip       (es_rf_zip),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BUS_W-1:0] mkBus(
        input logic [11:0] aluOp, input logic [3:0] divOp, input logic [1:0] size,
        input logic ld, input logic st, input logic [4:0] waddr,
        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd);
        return {aluOp, divOp, size, ld, st, 1'b1, waddr, s1, s2, rkd, 32'h1c00_0100};
    endfunction

    function automatic logic [31:0] busResult(input logic [41+XLEN-1:0] b);
        return b[XLEN+31:32];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [BUS_W-1:0] bus, input logic msAllow);
        @(negedge clk);
        ds2es_bus   = bus;
        ds2es_valid = 1'b1;
        ms_allowin  = msAllow;
        @(posedge clk);
        #1;
        ds2es_valid = 1'b0;
    endtask

    // Runs one divide with ms_allowin held high. The stage should stall for
    // exactly XLEN+1 cycles, with es2ms_valid low and the pending register
    // write visible on the zip, and then offer the expected result.
    task automatic runDivide(input string name, input logic [3:0] divOp,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        int  stall;
        bit  done;
        bit  early;
        bit  zipLost;
        stall   = 0;
        done    = 0;
        early   = 0;
        zipLost = 0;
        applyStimulus(mkBus(12'h000, divOp, 2'd2, 1'b0, 1'b0, 5'd7, a, b, 32'h0), 1'b1);
        for (int c = 0; c < 100 && !done; c++) begin
            if (es_allowin) begin
                done = 1;
            end else begin
                stall++;
                if (es2ms_valid) early = 1;
                if (es_rf_zip[XLEN+5] !== 1'b1) zipLost = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checkOutput({name, " timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, " stall cycles"}, 64'(stall), 64'd33);
            checkOutput({name, " result"}, {32'h0, busResult(es2ms_bus)}, {32'h0, exp});
            checkOutput({name, " es2ms_valid at done"}, {63'h0, es2ms_valid}, 64'd1);
        end
        checkOutput({name, " early es2ms_valid"}, {63'h0, early}, 64'd0);
        checkOutput({name, " zip rf_we during stall"}, {63'h0, zipLost}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit earlyValid;
        total       = 0;
        bad         = 0;
        resetn      = 1'b0;
        flush       = 1'b0;
        ds2es_valid = 1'b0;
        ds2es_bus   = '0;
        ms_allowin  = 1'b1;

        //                aluOp    size  ld st  s1            s2            rkd           expResult     en we       wdata
        vecs[0]  = '{OP_ADD,  2'd2, 0, 0, 32'd5,        32'd7,        32'h0,        32'd12,       0, 4'b0000, 32'h0};
        vecs[1]  = '{OP_SUB,  2'd2, 0, 0, 32'd5,        32'd7,        32'h0,        32'hFFFFFFFE, 0, 4'b0000, 32'h0};
        vecs[2]  = '{OP_SLT,  2'd2, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        0, 4'b0000, 32'h0};
        vecs[3]  = '{OP_SLTU, 2'd2, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        0, 4'b0000, 32'h0};
        vecs[4]  = '{OP_AND,  2'd2, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 0, 4'b0000, 32'h0};
        vecs[5]  = '{OP_NOR,  2'd2, 0, 0, 32'h0,        32'h0000FFFF, 32'h0,        32'hFFFF0000, 0, 4'b0000, 32'h0};
        vecs[6]  = '{OP_OR,   2'd2, 0, 0, 32'hF0000000, 32'h0000000F, 32'h0,        32'hF000000F, 0, 4'b0000, 32'h0};
        vecs[7]  = '{OP_XOR,  2'd2, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'hF0F0F0F0, 0, 4'b0000, 32'h0};
        vecs[8]  = '{OP_SLL,  2'd2, 0, 0, 32'd1,        32'h24,       32'h0,        32'h10,       0, 4'b0000, 32'h0};
        vecs[9]  = '{OP_SRL,  2'd2, 0, 0, 32'h80000000, 32'd4,        32'h0,        32'h08000000, 0, 4'b0000, 32'h0};
        vecs[10] = '{OP_SRA,  2'd2, 0, 0, 32'h80000000, 32'd4,        32'h0,        32'hF8000000, 0, 4'b0000, 32'h0};
        vecs[11] = '{OP_LUI,  2'd2, 0, 0, 32'h0,        32'h12345000, 32'h0,        32'h12345000, 0, 4'b0000, 32'h0};
        vecs[12] = '{OP_ADD,  2'd0, 0, 1, 32'h1000,     32'd3,        32'hAB,       32'h1003,     1, 4'b1000, 32'hABABABAB};
        vecs[13] = '{OP_ADD,  2'd1, 0, 1, 32'h1000,     32'd2,        32'h1234,     32'h1002,     1, 4'b1100, 32'h12341234};
        vecs[14] = '{OP_ADD,  2'd2, 0, 1, 32'h1000,     32'd4,        32'hDEADBEEF, 32'h1004,     1, 4'b1111, 32'hDEADBEEF};
        vecs[15] = '{OP_ADD,  2'd0, 0, 1, 32'h1000,     32'd1,        32'h5A,       32'h1001,     1, 4'b0010, 32'h5A5A5A5A};
        vecs[16] = '{OP_ADD,  2'd2, 1, 0, 32'h2000,     32'd8,        32'h0,        32'h2008,     1, 4'b0000, 32'h0};
        vecs[17] = '{OP_ADD,  2'd3, 0, 1, 32'h3000,     32'd0,        32'h11223344, 32'h3000,     1, 4'b0000, 32'h11223344};

        // Reset state.
        #1;
        checkOutput("reset es2ms_valid", {63'h0, es2ms_valid}, 64'd0);
        checkOutput("reset sram_en", {63'h0, data_sram_en}, 64'd0);
        checkOutput("reset sram_we", {60'h0, data_sram_we}, 64'd0);
        checkOutput("reset es_allowin", {63'h0, es_allowin}, 64'd1);
        checkOutput("reset zip flags", {62'h0, es_rf_zip[XLEN+6:XLEN+5]}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Single-cycle table.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(mkBus(vecs[i].aluOp, 4'b0000, vecs[i].size, vecs[i].ld, vecs[i].st,
                                5'd3, vecs[i].s1, vecs[i].s2, vecs[i].rkd), 1'b1);
            checkOutput($sformatf("vec%0d es2ms_valid", i), {63'h0, es2ms_valid}, 64'd1);
            checkOutput($sformatf("vec%0d result", i), {32'h0, busResult(es2ms_bus)}, {32'h0, vecs[i].expResult});
            checkOutput($sformatf("vec%0d es_allowin", i), {63'h0, es_allowin}, 64'd1);
            checkOutput($sformatf("vec%0d sram_en", i), {63'h0, data_sram_en}, {63'h0, vecs[i].expEn});
            checkOutput($sformatf("vec%0d sram_we", i), {60'h0, data_sram_we}, {60'h0, vecs[i].expWe});
            checkOutput($sformatf("vec%0d sram_wdata", i), {32'h0, data_sram_wdata}, {32'h0, vecs[i].expWdata});
        end
        @(posedge clk);
        #1;
        checkOutput("drain es2ms_valid", {63'h0, es2ms_valid}, 64'd0);

        // Store held by memory for two cycles, request only at handoff.
        applyStimulus(mkBus(OP_ADD, 4'b0000, 2'd0, 1'b0, 1'b1, 5'd0, 32'h1000, 32'd3, 32'hAB), 1'b0);
        checkOutput("stall st.b c1 sram_en", {63'h0, data_sram_en}, 64'd0);
        checkOutput("stall st.b c1 es_allowin", {63'h0, es_allowin}, 64'd0);
        checkOutput("stall st.b c1 es2ms_valid", {63'h0, es2ms_valid}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("stall st.b c2 sram_en", {63'h0, data_sram_en}, 64'd0);
        ms_allowin = 1'b1;
        #1;
        checkOutput("stall st.b handoff sram_en", {63'h0, data_sram_en}, 64'd1);
        checkOutput("stall st.b handoff we", {60'h0, data_sram_we}, 64'h8);
        checkOutput("stall st.b handoff wdata", {32'h0, data_sram_wdata}, 64'hABABABAB);
        checkOutput("stall st.b handoff es_allowin", {63'h0, es_allowin}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("stall st.b after sram_en", {63'h0, data_sram_en}, 64'd0);

        // Divides.
        runDivide("div -7/2", D_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        runDivide("mod -7/2", D_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        runDivide("divu 5/0", D_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
        runDivide("modu x/0", D_MODU, 32'h1234, 32'd0, 32'h1234);
        runDivide("div min/-1", D_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runDivide("mod min/-1", D_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        runDivide("divu 100/7", D_DIVU, 32'd100, 32'd7, 32'd14);
        runDivide("modu 100/7", D_MODU, 32'd100, 32'd7, 32'd2);
        runDivide("div -5/0", D_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
        runDivide("mod -5/0", D_MOD, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);

        // Flush at divide cycle 5 while decode offers an add.
        earlyValid = 0;
        applyStimulus(mkBus(12'h000, D_DIVU, 2'd2, 1'b0, 1'b0, 5'd7, 32'd1000, 32'd3, 32'h0), 1'b1);
        for (int c = 1; c < 5; c++) begin
            if (es2ms_valid) earlyValid = 1;
            @(posedge clk);
            #1;
        end
        flush       = 1'b1;
        ds2es_bus   = mkBus(OP_ADD, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd4, 32'd5, 32'd7, 32'h0);
        ds2es_valid = 1'b1;
        #1;
        if (es2ms_valid) earlyValid = 1;
        checkOutput("flush div es2ms_valid never", {63'h0, earlyValid}, 64'd0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        ds2es_valid = 1'b0;
        checkOutput("flush div es2ms_valid after", {63'h0, es2ms_valid}, 64'd0);
        checkOutput("flush div es_allowin after", {63'h0, es_allowin}, 64'd1);
        checkOutput("flush div zip rf_we after", {63'h0, es_rf_zip[XLEN+5]}, 64'd0);
        runDivide("divu after flush", D_DIVU, 32'd1000, 32'd3, 32'd333);

        // Flush into an empty stage must block the capture.
        @(negedge clk);
        flush       = 1'b1;
        ds2es_bus   = mkBus(OP_ADD, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd4, 32'd5, 32'd7, 32'h0);
        ds2es_valid = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        ds2es_valid = 1'b0;
        checkOutput("flush empty no capture", {63'h0, es2ms_valid}, 64'd0);

        // Reset asserted at divide cycle 10.
        applyStimulus(mkBus(12'h000, D_DIVU, 2'd2, 1'b0, 1'b0, 5'd7, 32'd77, 32'd5, 32'h0), 1'b1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("reset mid-run es2ms_valid", {63'h0, es2ms_valid}, 64'd0);
        checkOutput("reset mid-run es_allowin", {63'h0, es_allowin}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(mkBus(OP_ADD, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd2, 32'd5, 32'd7, 32'h0), 1'b1);
        checkOutput("post-reset add es2ms_valid", {63'h0, es2ms_valid}, 64'd1);
        checkOutput("post-reset add result", {32'h0, busResult(es2ms_bus)}, 64'd12);
        @(posedge clk);
        #1;
        runDivide("divu after reset", D_DIVU, 32'd77, 32'd5, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
